// File: rtl/arp_resolver_if.sv
// Signal bundle around the ARP resolver: lookup request/response, cache query and
// write ports, who-has transmit commands, parsed ARP replies and static IP configuration.
interface arp_resolver_if;
  logic        arp_request_valid;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip;

  logic        arp_response_valid;
  logic        arp_response_ready;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;

  logic        cache_query_request_valid;
  logic        cache_query_request_ready;
  logic [31:0] cache_query_request_ip;

  logic        cache_query_response_valid;
  logic        cache_query_response_ready;
  logic        cache_query_response_error;
  logic [47:0] cache_query_response_mac;

  logic        cache_write_request_valid;
  logic        cache_write_request_ready;
  logic [31:0] cache_write_request_ip;
  logic [47:0] cache_write_request_mac;

  logic        arp_tx_valid;
  logic        arp_tx_ready;
  logic [31:0] arp_tx_ip;

  logic        arp_reply_valid;
  logic        arp_reply_ready;
  logic [31:0] arp_reply_ip;
  logic [47:0] arp_reply_mac;

  logic [31:0] local_ip;
  logic [31:0] gateway_ip;
  logic [31:0] subnet_mask;

  // Resolver side.
  modport master (
    input  arp_request_valid, arp_request_ip,
    output arp_request_ready,
    output arp_response_valid, arp_response_error, arp_response_mac,
    input  arp_response_ready,
    output cache_query_request_valid, cache_query_request_ip,
    input  cache_query_request_ready,
    input  cache_query_response_valid, cache_query_response_error, cache_query_response_mac,
    output cache_query_response_ready,
    output cache_write_request_valid, cache_write_request_ip, cache_write_request_mac,
    input  cache_write_request_ready,
    output arp_tx_valid, arp_tx_ip,
    input  arp_tx_ready,
    input  arp_reply_valid, arp_reply_ip, arp_reply_mac,
    output arp_reply_ready,
    input  local_ip, gateway_ip, subnet_mask
  );

  // IP stack, cache and ARP frame engines side.
  modport slave (
    output arp_request_valid, arp_request_ip,
    input  arp_request_ready,
    input  arp_response_valid, arp_response_error, arp_response_mac,
    output arp_response_ready,
    input  cache_query_request_valid, cache_query_request_ip,
    output cache_query_request_ready,
    output cache_query_response_valid, cache_query_response_error, cache_query_response_mac,
    input  cache_query_response_ready,
    input  cache_write_request_valid, cache_write_request_ip, cache_write_request_mac,
    output cache_write_request_ready,
    input  arp_tx_valid, arp_tx_ip,
    output arp_tx_ready,
    output arp_reply_valid, arp_reply_ip, arp_reply_mac,
    input  arp_reply_ready,
    output local_ip, gateway_ip, subnet_mask
  );
endinterface

// File: rtl/arp_resolver.sv
// ARP lookup client: applies broadcast/subnet/gateway rules, queries the ARP cache and,
// on a miss, sends timed who-has retries; received replies are forwarded to the cache.
module arp_resolver #(
  parameter int RETRY_COUNT            = 4,
  parameter int REQUEST_RETRY_INTERVAL = 250000000,
  parameter int TIMER_WIDTH            = 36
) (
  input  logic           clk,
  input  logic           rst,
  arp_resolver_if.master bus
);
  localparam int RETRY_WIDTH = $clog2(RETRY_COUNT + 1);
  localparam logic [TIMER_WIDTH-1:0] INTERVAL = TIMER_WIDTH'(REQUEST_RETRY_INTERVAL);
  localparam logic [RETRY_WIDTH-1:0] RETRIES  = RETRY_WIDTH'(RETRY_COUNT);

  typedef enum logic [2:0] {
    S_IDLE, S_QUERY, S_WAIT_CACHE, S_SEND_REQ, S_WAIT_REPLY, S_RESPOND
  } state_e;

  state_e                 r_state;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic                   r_resp_error;
  logic [47:0]            r_resp_mac;
  logic                   r_cq_valid;
  logic                   r_cr_ready;
  logic                   r_tx_valid;
  logic [31:0]            r_target;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [RETRY_WIDTH-1:0] r_retries;

  logic                   r_reply_full;
  logic [31:0]            r_reply_ip;
  logic [47:0]            r_reply_mac;

  logic [31:0]            w_host_mask;
  logic                   w_is_bcast;
  logic                   w_on_link;
  logic                   w_reply_ready;
  logic                   w_reply_accept;
  logic                   w_reply_match;
  logic                   w_timer_done;

  assign w_host_mask    = ~bus.subnet_mask;
  assign w_is_bcast     = (bus.arp_request_ip == 32'hFFFF_FFFF) ||
                          ((bus.arp_request_ip & w_host_mask) == w_host_mask);
  assign w_on_link      = ((bus.arp_request_ip ^ bus.local_ip) & bus.subnet_mask) == 32'h0;
  assign w_reply_ready  = !r_reply_full || bus.cache_write_request_ready;
  assign w_reply_accept = bus.arp_reply_valid && w_reply_ready;
  // A reply completes the lookup in its accept cycle, before it reaches the buffer.
  assign w_reply_match  = w_reply_accept && (r_state == S_WAIT_REPLY) &&
                          (bus.arp_reply_ip == r_target);
  assign w_timer_done   = (r_timer <= TIMER_WIDTH'(1));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read in this block sees
    // the pre-edge value regardless of statement order.
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_mac   <= '0;
      r_cq_valid   <= 1'b0;
      r_cr_ready   <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_target     <= '0;
      r_timer      <= '0;
      r_retries    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (bus.arp_request_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            if (w_is_bcast) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_resp_mac   <= 48'hFFFF_FFFF_FFFF;
              r_state      <= S_RESPOND;
            end else begin
              r_target   <= w_on_link ? bus.arp_request_ip : bus.gateway_ip;
              r_cq_valid <= 1'b1;
              r_state    <= S_QUERY;
            end
          end
        end
        S_QUERY: begin
          if (bus.cache_query_request_ready) begin
            r_cq_valid <= 1'b0;
            r_cr_ready <= 1'b1;
            r_state    <= S_WAIT_CACHE;
          end
        end
        S_WAIT_CACHE: begin
          if (bus.cache_query_response_valid) begin
            r_cr_ready <= 1'b0;
            if (!bus.cache_query_response_error) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b0;
              r_resp_mac   <= bus.cache_query_response_mac;
              r_state      <= S_RESPOND;
            end else begin
              r_retries  <= RETRIES;
              r_tx_valid <= 1'b1;
              r_state    <= S_SEND_REQ;
            end
          end
        end
        S_SEND_REQ: begin
          if (bus.arp_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_retries  <= r_retries - RETRY_WIDTH'(1);
            r_timer    <= INTERVAL;
            r_state    <= S_WAIT_REPLY;
          end
        end
        S_WAIT_REPLY: begin
          if (w_reply_match) begin
            r_timer      <= '0;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
            r_resp_mac   <= bus.arp_reply_mac;
            r_state      <= S_RESPOND;
          end else if (w_timer_done) begin
            r_timer <= '0;
            if (r_retries != '0) begin
              r_tx_valid <= 1'b1;
              r_state    <= S_SEND_REQ;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_mac   <= '0;
              r_state      <= S_RESPOND;
            end
          end else begin
            r_timer <= r_timer - TIMER_WIDTH'(1);
          end
        end
        S_RESPOND: begin
          if (bus.arp_response_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Single-entry reply buffer; reloads in the same cycle it drains so replies stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reply_full <= 1'b0;
      r_reply_ip   <= '0;
      r_reply_mac  <= '0;
    end else if (w_reply_accept) begin
      r_reply_full <= 1'b1;
      r_reply_ip   <= bus.arp_reply_ip;
      r_reply_mac  <= bus.arp_reply_mac;
    end else if (bus.cache_write_request_ready) begin
      r_reply_full <= 1'b0;
    end
  end

  assign bus.arp_request_ready          = r_req_ready;
  assign bus.arp_response_valid         = r_resp_valid;
  assign bus.arp_response_error         = r_resp_error;
  assign bus.arp_response_mac           = r_resp_mac;
  assign bus.cache_query_request_valid  = r_cq_valid;
  assign bus.cache_query_request_ip     = r_target;
  assign bus.cache_query_response_ready = r_cr_ready;
  assign bus.arp_tx_valid               = r_tx_valid;
  assign bus.arp_tx_ip                  = r_target;
  assign bus.cache_write_request_valid  = r_reply_full;
  assign bus.cache_write_request_ip     = r_reply_ip;
  assign bus.cache_write_request_mac    = r_reply_mac;
  assign bus.arp_reply_ready            = w_reply_ready;
endmodule

// File: tb/tb_arp_resolver.sv
// Scoreboard bench for arp_resolver: stimulus pushes expected cache queries, who-has
// commands, cache writes and lookup responses; a negedge monitor pops and compares them.
module tb_arp_resolver;
  localparam int          RETRIES  = 3;
  localparam int          INTERVAL = 100;
  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0180;
  localparam logic [31:0] GW_IP    = 32'hC0A8_0101;
  localparam logic [31:0] MASK     = 32'hFFFF_FF00;

  typedef struct { logic [31:0] ip; logic [47:0] mac; } wr_t;
  typedef struct { logic err; logic [47:0] mac; } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  arp_resolver_if bus();

  arp_resolver #(
    .RETRY_COUNT(RETRIES), .REQUEST_RETRY_INTERVAL(INTERVAL), .TIMER_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_query_q[$];
  logic [31:0] exp_tx_q[$];
  wr_t         exp_wr_q[$];
  resp_t       exp_resp_q[$];

  int   tx_cyc[$];
  int   tx_seen = 0;
  int   resp_seen = 0;
  int   req_acc_cyc = 0;
  int   cresp_acc_cyc = 0;
  int   query_rise_cyc = 0;
  int   resp_rise_cyc = 0;
  bit   rand_en = 1'b0;
  bit   cur_hit = 1'b0;
  logic [47:0] cur_mac = '0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [47:0] rand_mac();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure from the environment when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_en) begin
      bus.cache_query_request_ready = ($urandom_range(0, 1) == 1);
      bus.arp_tx_ready              = ($urandom_range(0, 3) != 0);
      bus.arp_response_ready        = ($urandom_range(0, 1) == 1);
      bus.cache_write_request_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every output handshake against the scoreboard queues.
  initial begin
    bit    q_prev = 1'b0;
    bit    r_prev = 1'b0;
    resp_t r;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.cache_query_request_valid && !q_prev) query_rise_cyc = cyc;
        if (bus.arp_response_valid && !r_prev) resp_rise_cyc = cyc;
        q_prev = bus.cache_query_request_valid;
        r_prev = bus.arp_response_valid;
        if (bus.cache_query_request_valid && bus.cache_query_request_ready) begin
          if (exp_query_q.size() == 0) check("unexpected_query", exp_query_q.size(), 1);
          else check("query_ip", bus.cache_query_request_ip, exp_query_q.pop_front());
        end
        if (bus.arp_tx_valid && bus.arp_tx_ready) begin
          tx_seen++;
          tx_cyc.push_back(cyc);
          if (exp_tx_q.size() == 0) check("unexpected_arp_tx", exp_tx_q.size(), 1);
          else check("arp_tx_ip", bus.arp_tx_ip, exp_tx_q.pop_front());
        end
        if (bus.cache_write_request_valid && bus.cache_write_request_ready) begin
          if (exp_wr_q.size() == 0) check("unexpected_cache_write", exp_wr_q.size(), 1);
          else begin
            w = exp_wr_q.pop_front();
            check("cache_write_ip", bus.cache_write_request_ip, w.ip);
            check("cache_write_mac", bus.cache_write_request_mac, w.mac);
          end
        end
        if (bus.arp_response_valid && bus.arp_response_ready) begin
          resp_seen++;
          if (exp_resp_q.size() == 0) check("unexpected_response", exp_resp_q.size(), 1);
          else begin
            r = exp_resp_q.pop_front();
            check("resp_error", bus.arp_response_error, r.err);
            check("resp_mac", bus.arp_response_mac, r.mac);
          end
        end
      end else begin
        q_prev = 1'b0;
        r_prev = 1'b0;
      end
    end
  end

  // Cache model: answers each accepted query with the hit/miss chosen by the stimulus.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.cache_query_request_valid && bus.cache_query_request_ready) begin
      int n = 0;
      @(posedge clk);
      #1;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.cache_query_response_valid = 1'b1;
      bus.cache_query_response_error = !cur_hit;
      bus.cache_query_response_mac   = cur_hit ? cur_mac : rand_mac();
      do begin @(negedge clk); n++; end while (!bus.cache_query_response_ready && n < 100);
      if (!bus.cache_query_response_ready) check("cache_resp_ready_timeout", bus.cache_query_response_ready, 1);
      cresp_acc_cyc = cyc;
      @(posedge clk);
      #1;
      bus.cache_query_response_valid = 1'b0;
    end
  end

  task automatic set_ready(input bit v);
    rand_en = 1'b0;
    bus.cache_query_request_ready = v;
    bus.arp_tx_ready              = v;
    bus.arp_response_ready        = v;
    bus.cache_write_request_ready = v;
  endtask

  task automatic send_request(input logic [31:0] ip);
    int n = 0;
    bus.arp_request_ip    = ip;
    bus.arp_request_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.arp_request_ready && n < 100);
    if (!bus.arp_request_ready) check("req_ready_timeout", bus.arp_request_ready, 1);
    req_acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.arp_request_valid = 1'b0;
  endtask

  task automatic send_reply(input logic [31:0] ip, input logic [47:0] mac);
    int n = 0;
    bus.arp_reply_ip    = ip;
    bus.arp_reply_mac   = mac;
    bus.arp_reply_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.arp_reply_ready && n < 100);
    if (!bus.arp_reply_ready) check("reply_ready_timeout", bus.arp_reply_ready, 1);
    exp_wr_q.push_back('{ip: ip, mac: mac});
    @(posedge clk);
    #1;
    bus.arp_reply_valid = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_seen < target && n < 1000) begin @(negedge clk); n++; end
    if (tx_seen < target) check("arp_tx_timeout", tx_seen, target);
  endtask

  // Issues one lookup and its environment behaviour; expectations come from the
  // broadcast / on-link / gateway rules and the retry policy.
  task automatic do_lookup(input logic [31:0] ip, input bit hit, input logic [47:0] mac,
                           input int reply_after, input bit nonmatch, input logic [47:0] reply_mac);
    logic [31:0] target;
    bit          bcast;
    int          base_tx;
    int          base_resp;
    int          n;
    @(posedge clk);
    #1;
    base_tx   = tx_seen;
    base_resp = resp_seen;
    bcast  = (ip == 32'hFFFF_FFFF) || ((ip | MASK) == 32'hFFFF_FFFF);
    target = ((ip & MASK) == (LOCAL_IP & MASK)) ? ip : GW_IP;
    if (bcast) begin
      exp_resp_q.push_back('{err: 1'b0, mac: 48'hFFFF_FFFF_FFFF});
    end else begin
      exp_query_q.push_back(target);
      cur_hit = hit;
      cur_mac = mac;
      if (hit) exp_resp_q.push_back('{err: 1'b0, mac: mac});
      else begin
        for (int i = 0; i < ((reply_after > 0) ? reply_after : RETRIES); i++) exp_tx_q.push_back(target);
        if (reply_after > 0) exp_resp_q.push_back('{err: 1'b0, mac: reply_mac});
        else exp_resp_q.push_back('{err: 1'b1, mac: 48'h0});
      end
    end
    send_request(ip);
    if (!bcast && !hit && (reply_after > 0 || nonmatch)) begin
      wait_tx(base_tx + ((reply_after > 0) ? reply_after : 1));
      repeat ($urandom_range(2, 10)) @(posedge clk);
      #1;
      if (nonmatch) send_reply(target ^ 32'($urandom_range(1, 255)), rand_mac());
      if (reply_after > 0) send_reply(target, reply_mac);
    end
    n = 0;
    while (resp_seen == base_resp && n < 3000) begin @(negedge clk); n++; end
    if (resp_seen == base_resp) check("response_timeout", resp_seen, base_resp + 1);
    n = 0;
    while (exp_wr_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("leftover_query", exp_query_q.size(), 0);
    check("leftover_arp_tx", exp_tx_q.size(), 0);
    check("leftover_cache_write", exp_wr_q.size(), 0);
  endtask

  initial begin
    int          d;
    logic [31:0] rip;
    logic [47:0] m1;
    bus.arp_request_valid          = 1'b0;
    bus.arp_request_ip             = '0;
    bus.cache_query_response_valid = 1'b0;
    bus.cache_query_response_error = 1'b0;
    bus.cache_query_response_mac   = '0;
    bus.arp_reply_valid            = 1'b0;
    bus.arp_reply_ip               = '0;
    bus.arp_reply_mac              = '0;
    bus.local_ip                   = LOCAL_IP;
    bus.gateway_ip                 = GW_IP;
    bus.subnet_mask                = MASK;
    set_ready(1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", bus.arp_request_ready, 0);
    check("reset_valids", {bus.arp_response_valid, bus.cache_query_request_valid,
                           bus.arp_tx_valid, bus.cache_write_request_valid}, 0);
    check("reset_resp_err_mac", {bus.arp_response_error, bus.arp_response_mac}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("req_ready_first_cycle", bus.arp_request_ready, 0);
    @(negedge clk);
    check("req_ready_after_reset", bus.arp_request_ready, 1);

    // On-link cache hit, with latency checks.
    do_lookup(32'hC0A8_0105, 1'b1, 48'h0A0B_0C0D_0E0F, 0, 1'b0, '0);
    check("hit_query_latency", query_rise_cyc, req_acc_cyc + 1);
    check("hit_resp_latency", resp_rise_cyc, cresp_acc_cyc + 1);
    // Off-link goes through the gateway.
    do_lookup(32'h0808_0808, 1'b1, 48'h0203_0405_0607, 0, 1'b0, '0);
    // Broadcasts bypass the cache.
    do_lookup(32'hC0A8_01FF, 1'b0, '0, 0, 1'b0, '0);
    do_lookup(32'hFFFF_FFFF, 1'b0, '0, 0, 1'b0, '0);

    // Miss with no reply: retries spaced by the interval, then error.
    tx_cyc.delete();
    do_lookup(32'hC0A8_0110, 1'b0, '0, 0, 1'b0, '0);
    check("noreply_tx_count", tx_cyc.size(), RETRIES);
    for (int i = 1; i < tx_cyc.size(); i++) begin
      d = tx_cyc[i] - tx_cyc[i-1];
      check("tx_spacing_in_range", (d >= INTERVAL && d <= INTERVAL + 2), 1);
    end
    if (tx_cyc.size() > 0) begin
      d = resp_rise_cyc - tx_cyc[tx_cyc.size()-1];
      check("final_timeout_in_range", (d >= INTERVAL && d <= INTERVAL + 2), 1);
    end

    // Miss answered after the second who-has, preceded by a non-matching reply.
    do_lookup(32'hC0A8_0105, 1'b0, '0, 2, 1'b1, 48'h1122_3344_5566);

    // Write port stalled: second reply must wait, then stream without a bubble.
    @(posedge clk);
    #1;
    bus.cache_write_request_ready = 1'b0;
    send_reply(32'hC0A8_0121, 48'hAAAA_0000_0001);
    bus.arp_reply_ip    = 32'hC0A8_0122;
    bus.arp_reply_mac   = 48'hAAAA_0000_0002;
    bus.arp_reply_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_reply_ready", bus.arp_reply_ready, 0);
    check("stall_write_ip", bus.cache_write_request_ip, 32'hC0A8_0121);
    @(posedge clk);
    #1 bus.cache_write_request_ready = 1'b1;
    @(negedge clk);
    check("release_reply_ready", bus.arp_reply_ready, 1);
    exp_wr_q.push_back('{ip: 32'hC0A8_0122, mac: 48'hAAAA_0000_0002});
    @(posedge clk);
    #1 bus.arp_reply_valid = 1'b0;
    @(negedge clk);
    check("no_bubble_write_valid", bus.cache_write_request_valid, 1);
    check("no_bubble_write_ip", bus.cache_write_request_ip, 32'hC0A8_0122);
    @(negedge clk);
    check("buffer_drained", bus.cache_write_request_valid, 0);

    // Reset while waiting for a reply, with a reply stuck in the buffer.
    @(posedge clk);
    #1;
    cur_hit = 1'b0;
    d = tx_seen;
    exp_query_q.push_back(32'hC0A8_0107);
    exp_tx_q.push_back(32'hC0A8_0107);
    send_request(32'hC0A8_0107);
    wait_tx(d + 1);
    @(posedge clk);
    #1 bus.cache_write_request_ready = 1'b0;
    send_reply(32'hC0A8_0199, 48'hBBBB_0000_0001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_valids_cleared", {bus.arp_response_valid, bus.cache_query_request_valid,
                                 bus.arp_tx_valid, bus.cache_write_request_valid}, 0);
    check("rst_req_ready", bus.arp_request_ready, 0);
    exp_query_q.delete();
    exp_tx_q.delete();
    exp_wr_q.delete();
    exp_resp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    set_ready(1'b1);
    repeat (2) @(negedge clk);
    check("rst_recovery_ready", bus.arp_request_ready, 1);
    do_lookup(32'hC0A8_0133, 1'b1, 48'h0C0D_0E0F_1011, 0, 1'b0, '0);

    // Randomized lookups under random backpressure.
    rand_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       rip = {24'hC0A801, 8'($urandom_range(1, 254))};
        1:       rip = {8'($urandom_range(1, 191)), 24'($urandom())};
        2:       rip = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'hC0A8_01FF;
        default: rip = 32'($urandom());
      endcase
      m1 = rand_mac();
      do_lookup(rip, ($urandom_range(0, 1) == 1), m1, $urandom_range(0, RETRIES),
                ($urandom_range(0, 1) == 1), rand_mac());
    end
    set_ready(1'b1);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
